// File: rtl/morse_key_decoder.sv
// rtl/morse_key_decoder.sv - Morse key timing, element assembly and glyph lookup
// Times key marks/spaces on a unit tick and emits code + 7-seg glyph on valid/ready.
module morse_key_decoder #(
  parameter int MAX_SYMS   = 4,
  parameter int DASH_TICKS = 3,
  parameter int GAP_TICKS  = 3,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_in,
  input  logic                    tick,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*MAX_SYMS-1:0]   code_out,
  output logic [6:0]              seg_out,
  output logic                    char_err,
  output logic                    overrun
);

  localparam int CW = 2 * MAX_SYMS;
  localparam int SW = $clog2(MAX_SYMS + 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  state_t           state;
  logic             key_prev;
  logic [CNT_W-1:0] counter;
  logic [CW-1:0]    code;
  logic [SW-1:0]    sym_cnt;
  logic             ovf;

  logic       rise, fall;
  logic [1:0] element;
  logic [7:0] hit_seg;

  // Returns {hit, glyph}; glyph is blank on a miss.
  function automatic logic [7:0] lookup(input logic [CW-1:0] c);
    case (c)
      CW'(8'h06): lookup = {1'b1, 7'b0001000};
      CW'(8'h95): lookup = {1'b1, 7'b1100000};
      CW'(8'h99): lookup = {1'b1, 7'b0110001};
      CW'(8'h25): lookup = {1'b1, 7'b1000010};
      CW'(8'h01): lookup = {1'b1, 7'b0110000};
      CW'(8'h59): lookup = {1'b1, 7'b0111000};
      CW'(8'h29): lookup = {1'b1, 7'b0100001};
      CW'(8'h55): lookup = {1'b1, 7'b1001000};
      CW'(8'h05): lookup = {1'b1, 7'b1111001};
      CW'(8'h6A): lookup = {1'b1, 7'b1000011};
      CW'(8'h65): lookup = {1'b1, 7'b1110001};
      CW'(8'h09): lookup = {1'b1, 7'b1101010};
      CW'(8'h2A): lookup = {1'b1, 7'b0000001};
      CW'(8'h69): lookup = {1'b1, 7'b0011000};
      CW'(8'hA6): lookup = {1'b1, 7'b0001100};
      CW'(8'h19): lookup = {1'b1, 7'b1111010};
      CW'(8'h15): lookup = {1'b1, 7'b0100100};
      CW'(8'h02): lookup = {1'b1, 7'b1110000};
      CW'(8'h16): lookup = {1'b1, 7'b1000001};
      CW'(8'h9A): lookup = {1'b1, 7'b1000100};
      default:    lookup = {1'b0, 7'b1111111};
    endcase
  endfunction

  assign rise    = key_in & ~key_prev;
  assign fall    = ~key_in & key_prev;
  assign element = (counter >= CNT_W'(DASH_TICKS)) ? 2'b10 : 2'b01;
  assign hit_seg = lookup(code);

  // key_prev resets high so a key already held at reset release is not a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_prev  <= 1'b1;
      counter   <= '0;
      code      <= '0;
      sym_cnt   <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      code_out  <= '0;
      seg_out   <= 7'b1111111;
      char_err  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      key_prev <= key_in;
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state   <= MARK;
            counter <= '0;
            code    <= '0;
            sym_cnt <= '0;
            ovf     <= 1'b0;
          end
        end
        MARK: begin
          if (fall) begin
            if (sym_cnt < SW'(MAX_SYMS)) begin
              code    <= {code[CW-3:0], element};
              sym_cnt <= sym_cnt + SW'(1);
            end else begin
              ovf <= 1'b1;
            end
            state   <= SPACE;
            counter <= '0;
          end else if (tick && counter != {CNT_W{1'b1}}) begin
            counter <= counter + CNT_W'(1);
          end
        end
        SPACE: begin
          if (rise) begin
            state   <= MARK;
            counter <= '0;
          end else if (tick) begin
            if (counter >= CNT_W'(GAP_TICKS - 1)) begin
              state   <= IDLE;
              counter <= '0;
              // A held character may only be replaced when it leaves this cycle.
              if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                code_out  <= code;
                seg_out   <= ovf ? 7'b1111111 : hit_seg[6:0];
                char_err  <= ovf | ~hit_seg[7];
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              counter <= counter + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/morse_key_decoder.md
# morse_key_decoder

Parametrised Morse character decoder driven directly by a debounced key line. It times key marks and spaces against a unit-time tick, assembles dot/dash elements into a packed code word, and detects the inter-character gap. On that gap it looks the code up in a 7-segment glyph table and presents code, glyph and error flag on a valid/ready output port. It sits between the key debouncer and the display/transmit path, replacing the fixed 8-bit, pre-assembled-code decoder.

## Interface
- MAX_SYMS, 4: maximum elements per character; code width CW = 2*MAX_SYMS (MAX_SYMS >= 4).
- DASH_TICKS, 3: mark length in ticks at or above which an element is a dash.
- GAP_TICKS, 3: space length in ticks that ends a character.
- CNT_W, 8: tick counter width.

- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- key_in  in  1  debounced key, synchronous to clk, 1 = key down.
- tick  in  1  one-clk unit-time enable.
- out_valid  out  1  character held on outputs.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- code_out  out  CW  packed code: 2 bits/element, 01 = dot, 10 = dash, first element most significant, right-aligned, upper bits 0.
- seg_out  out  7  active-low glyph, bit order abcdefg.
- char_err  out  1  code unknown or element overflow.
- overrun  out  1  sticky: a completed character was dropped.

## Operation
- States IDLE, MARK, SPACE. key_prev register detects edges.
- IDLE: key rise -> MARK, counter = 0, code = 0, sym_cnt = 0, ovf = 0.
- MARK: counter += 1 on tick, saturating at 2^CNT_W-1. Key fall: element = dash if counter >= DASH_TICKS else dot (zero-tick mark is a dot). If sym_cnt < MAX_SYMS: code = (code << 2) | element, sym_cnt += 1; else ovf = 1, code unchanged. -> SPACE, counter = 0.
- SPACE: counter += 1 on tick. Key rise before counter reaches GAP_TICKS -> MARK, counter = 0, code kept. Counter reaching GAP_TICKS -> emit, -> IDLE.
- Emit: if out_valid = 0 or being accepted this cycle, load code_out = code, seg_out = lookup, char_err = ovf | miss, out_valid = 1. Otherwise discard character, set overrun.
- Lookup (hex code -> seg_out): A 06 -> 0001000, B 95 -> 1100000, C 99 -> 0110001, D 25 -> 1000010, E 01 -> 0110000, F 59 -> 0111000, G 29 -> 0100001, H 55 -> 1001000, I 05 -> 1111001, J 6A -> 1000011, L 65 -> 1110001, N 09 -> 1101010, O 2A -> 0000001, P 69 -> 0011000, Q A6 -> 0001100, R 19 -> 1111010, S 15 -> 0100100, T 02 -> 1110000, U 16 -> 1000001, Y 9A -> 1000100. Codes compared zero-extended to CW. Any other code (K, M, V, W, X, Z, digits, longer codes) is a miss.
- Miss or ovf: seg_out = 1111111 (blank), char_err = 1.
- Accept (out_valid & out_ready) clears out_valid; data outputs hold last value.

## Timing
- Reset values: out_valid 0, code_out 0, seg_out 1111111, char_err 0, overrun 0; FSM IDLE, counter 0.
- Edges act in the clk they are seen (key_in != key_prev); outputs registered.
- Key edge and tick in same clk: edge wins, counter cleared, tick ignored.
- out_valid rises the clk after the tick that brings the SPACE counter to GAP_TICKS.
- Emit and accept in same clk: new character loads, out_valid stays 1, no overrun.
- Reset mid-character or with out_valid = 1: partial code and pending output discarded, overrun cleared.
- A key held down in IDLE after reset is ignored until the next rise.

## Test plan
- Defaults, out_ready = 1: mark 1 tick, space 1, mark 3, space 3 -> code_out 06, seg_out 0001000, char_err 0, one out_valid cycle.
- Mark 0 ticks (press/release inside one tick), gap 3 -> code 01, seg 0110000 (E); mark 5 ticks -> code 02, seg 1110000 (T).
- Four dashes -> code AA, seg 1111111, char_err 1; five dots -> code 55, char_err 1 (ovf).
- out_ready = 0: send A then E -> outputs hold A, overrun = 1; raise out_ready -> out_valid drops after one clk, overrun stays 1.
- Assert rst after two elements of B -> all outputs at reset values; next character I decodes to code 05, seg 1111001.
- MAX_SYMS = 5, code Q sent -> code_out 0A6 (10 bits), seg 0001100.
